spi_peripheral: RTL and testbench
=================================

# spi_peripheral

Serial configuration front-end for the PWM peripheral. Receives write-only SPI mode-0 frames from off-chip on raw input pins, synchronizes them into the `clk` domain, decodes a 7-bit register address, and holds the five 8-bit configuration registers that drive `pwm_peripheral`: output enables, PWM enables, and duty cycle. Instantiated in the top-level wrapper between the dedicated inputs and the PWM block.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchronizer; minimum 2.
- `MAX_ADDR`, default 7'h04: highest valid register address.

Ports:
- `clk`  in  1  system clock. One clock only.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sclk`  in  1  raw SPI clock, asynchronous to `clk`.
- `copi`  in  1  raw SPI data in, asynchronous.
- `ncs`  in  1  raw SPI chip select, active-low, asynchronous.
- `en_reg_out_7_0`  out  8  register 0x00, output enable for bits 7:0.
- `en_reg_out_15_8`  out  8  register 0x01, output enable for bits 15:8.
- `en_reg_pwm_7_0`  out  8  register 0x02, PWM mode enable for bits 7:0.
- `en_reg_pwm_15_8`  out  8  register 0x03, PWM mode enable for bits 15:8.
- `pwm_duty_cycle`  out  8  register 0x04, duty cycle (0x00 = 0 %, 0xFF = 100 %).

## Operation
- Reset values:
  - All five registers = 0x00.
  - FSM in IDLE. Bit counter = 0. Shift register = 0.
  - `sclk` synchronizer = 0. `ncs` synchronizer = 1. `copi` synchronizer = 0.
- Frame format: SPI mode 0, MSB first, 16 bits.
  - bit15: R/W, where 1 = write.
  - bits14:8: address.
  - bits7:0: data.
- Edge detection uses the synchronized signals plus one history flop:
  - `sclk_rise` = synced high AND previous low.
  - `ncs_fall` and `ncs_rise` are derived the same way.
- FSM states:
  - IDLE: on `ncs_fall`, clear the counter and shift register, go to SHIFT.
  - SHIFT: on `sclk_rise`, shift in synced `copi`; the counter increments and saturates at 17. On `ncs_rise`, go to COMMIT if count == 16 and bit15 == 1; otherwise go to IDLE (frame discarded).
  - COMMIT: if address ≤ `MAX_ADDR`, write the data byte to the addressed register. Return to IDLE unconditionally.
- Discard conditions, with all registers unchanged:
  - read frames (bit15 = 0);
  - address > `MAX_ADDR`;
  - fewer than 16 bits;
  - more than 16 bits.
- Simultaneous events:
  - `ncs_rise` and `sclk_rise` in the same cycle: `ncs_rise` wins and the SCLK edge is ignored.
  - `ncs_fall` seen in SHIFT is impossible by construction and is ignored.
- Only one register changes per frame. Registers hold their value indefinitely otherwise.
- Reset mid-frame: all state returns to reset values immediately.
  - If `ncs` is still low at release, the synced `ncs` falls after reset. This starts a partial frame, which is discarded by the count check.

## Timing
- Synchronizer latency: `SYNC_STAGES` clk edges; edge detect adds 1 edge.
- Commit latency (`SYNC_STAGES` = 2): the addressed register updates on the 4th `clk` rising edge after the first edge that samples raw `ncs` high.
- Requirements on the SPI master:
  - SCLK high and low phases each ≥ 3 `clk` periods (SCLK ≤ clk/8 recommended).
  - `copi` stable from ≥ 3 `clk` before to ≥ 3 `clk` after each SCLK rise.
  - `ncs` high time between frames ≥ 4 `clk` periods.
- Outputs are registered and glitch-free; they change only on `clk` rising edges, in the COMMIT state.

## Structure
- Package `spi_cfg_pkg` contains:
  - address constants `ADDR_EN_OUT_LO` = 0x00 through `ADDR_DUTY` = 0x04;
  - `FRAME_BITS` = 16;
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module `sync_edge`: `SYNC_STAGES`-deep synchronizer with a reset-value parameter, a history flop, and `rise`/`fall` outputs.
  - Instantiated three times: `sclk`, `copi`, `ncs`. The `copi` instance uses only its level output.
- Top of `spi_peripheral` contains: the FSM, the 5-bit counter, the 16-bit shift register, and the register file with address decode.

## Test plan
- Reset: hold `rst_n` low with random pins → all five outputs read 0x00. Release with `ncs` high → outputs stay 0x00.
- Write frame {1, 7'h00, 8'hF0} with SCLK = clk/10 → `en_reg_out_7_0` = 0xF0 within 4 clk of `ncs` rising; the other four stay 0x00.
- Back-to-back writes:
  - {1, 7'h04, 8'h80} → `pwm_duty_cycle` = 0x80;
  - {1, 7'h03, 8'hA5} → `en_reg_pwm_15_8` = 0xA5;
  - the earlier values hold.
- Rejected frames, each leaving all outputs unchanged:
  - read {0, 7'h01, 8'h55};
  - invalid addresses {1, 7'h05, 8'hFF} and {1, 7'h7F, 8'hFF}.
- Malformed frames: 15-bit and 17-bit writes to 0x02 → no change; a following valid write {1, 7'h02, 8'h3C} → `en_reg_pwm_7_0` = 0x3C.
- Reset mid-frame: assert `rst_n` after 9 bits of a write to 0x01, release with `ncs` low, finish the frame → all outputs 0x00. The next full write {1, 7'h01, 8'h0F} → `en_reg_out_15_8` = 0x0F.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM encoding for the SPI configuration front-end.
package spi_cfg_pkg;
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int FRAME_BITS = 16;
    localparam int CNT_SAT    = FRAME_BITS + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;
endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchronizer for one raw pin, with a history flop for edge detection.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = level_o & ~hist_q;
    assign fall_o  = ~level_o & hist_q;
endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 receiver holding the five PWM configuration registers.
module spi_peripheral
    import spi_cfg_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));

    assign unused_edges = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s};

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic        commit_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        commit_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shreg_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // End of frame takes priority over a coincident SCLK edge.
                if (ncs_rise) begin
                    state_d = (cnt_q == 5'(FRAME_BITS) && shreg_q[15]) ? COMMIT : IDLE;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[14:0], copi_s};
                    cnt_d   = (cnt_q == 5'(CNT_SAT)) ? cnt_q : cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                commit_we = (shreg_q[14:8] <= MAX_ADDR);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (commit_we) begin
            case (shreg_q[14:8])
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg_q[7:0];
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg_q[7:0];
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg_q[7:0];
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg_q[7:0];
                ADDR_DUTY:      pwm_duty_cycle  <= shreg_q[7:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed vector table, corner sequences, random frames vs. a register model.
module tb_spi_peripheral;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle));

    always #5 clk = ~clk;

    typedef struct {
        int          nbits;
        logic [31:0] frame;
        logic [39:0] exp;   // {duty, pwm_hi, pwm_lo, out_hi, out_lo}
    } vec_t;

    vec_t        tbl[9];
    logic [7:0]  mdl[5];
    int          nvec = 0;
    int          nerr = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [39:0] e);
        cmp({tag, " out_7_0"},  en_reg_out_7_0,  e[7:0]);
        cmp({tag, " out_15_8"}, en_reg_out_15_8, e[15:8]);
        cmp({tag, " pwm_7_0"},  en_reg_pwm_7_0,  e[23:16]);
        cmp({tag, " pwm_15_8"}, en_reg_pwm_15_8, e[31:24]);
        cmp({tag, " duty"},     pwm_duty_cycle,  e[39:32]);
    endtask

    function automatic logic [39:0] mdl_vec();
        return {mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    // SCLK = clk/10: 5 clk low, 5 clk high per bit.
    task automatic spi_begin();
        ncs = 1'b0;
        tick(5);
    endtask

    task automatic spi_bits(input logic [31:0] f, input int hi, input int lo);
        for (int b = hi; b >= lo; b--) begin
            copi = f[b];
            tick(5);
            sclk = 1'b1;
            tick(5);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        tick(5);
        ncs = 1'b1;
    endtask

    task automatic send(input logic [31:0] f, input int n);
        spi_begin();
        spi_bits(f, n - 1, 0);
        spi_end();
        tick(10);
    endtask

    // Reference: a frame lands only if it is exactly 16 bits, a write, and addresses a real register.
    task automatic model_frame(input logic [31:0] f, input int n);
        int addr;
        addr = int'(f[14:8]);
        if (n == 16 && f[15] == 1'b1 && addr <= 4)
            mdl[addr] = f[7:0];
    endtask

    initial begin
        int lat;
        tbl[0] = '{16, 32'h80F0,  40'h00_00_00_00_F0};
        tbl[1] = '{16, 32'h8480,  40'h80_00_00_00_F0};
        tbl[2] = '{16, 32'h83A5,  40'h80_A5_00_00_F0};
        tbl[3] = '{16, 32'h0155,  40'h80_A5_00_00_F0};
        tbl[4] = '{16, 32'h85FF,  40'h80_A5_00_00_F0};
        tbl[5] = '{16, 32'hFFFF,  40'h80_A5_00_00_F0};
        tbl[6] = '{15, 32'h4155,  40'h80_A5_00_00_F0};
        tbl[7] = '{17, 32'h10555, 40'h80_A5_00_00_F0};
        tbl[8] = '{16, 32'h823C,  40'h80_A5_3C_00_F0};

        // Reset with scrambled pins.
        sclk = 1'($urandom); copi = 1'($urandom); ncs = 1'($urandom);
        tick(5);
        check_all("in_reset", 40'h0);
        sclk = 1'b0; ncs = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check_all("post_reset", 40'h0);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].frame, tbl[i].nbits);
            check_all($sformatf("vec%0d", i), tbl[i].exp);
        end
        for (int i = 0; i < 5; i++) mdl[i] = tbl[8].exp[i*8 +: 8];

        // Commit latency: register must change by the 4th edge after ncs goes high.
        spi_begin();
        spi_bits(32'h8177, 15, 0);
        spi_end();
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (en_reg_out_15_8 == 8'h77) begin lat = i; break; end
        end
        nvec++;
        if (lat == 0 || lat > 4) begin
            nerr++;
            $display("FAIL commit_latency: got %0d edges expected <= 4", lat);
        end
        tick(10);
        mdl[1] = 8'h77;
        check_all("latency", mdl_vec());

        // Random frames, including short, long, read and out-of-range ones.
        for (int k = 0; k < 40; k++) begin
            logic [31:0] f;
            int n;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : 16;
            f = $urandom;
            if ($urandom_range(0, 4) != 0) f[n-1] = 1'b1;
            if (n == 16) f[14:8] = ($urandom_range(0, 7) == 0) ? 7'h7F : 7'($urandom_range(0, 6));
            send(f, n);
            model_frame(f[31:0], n);
            check_all($sformatf("rnd%0d", k), mdl_vec());
        end

        // Reset mid-frame: 9 bits, reset, release with ncs low, finish the frame.
        spi_begin();
        spi_bits(32'h81AB, 15, 7);
        rst_n = 1'b0;
        tick(3);
        check_all("midframe_rst", 40'h0);
        rst_n = 1'b1;
        tick(3);
        spi_bits(32'h81AB, 6, 0);
        spi_end();
        tick(10);
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        check_all("partial_discard", mdl_vec());
        send(32'h810F, 16);
        mdl[1] = 8'h0F;
        check_all("after_rst_write", mdl_vec());

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
